// File: rtl/tage_top.sv
`default_nettype none
// ============================================================================
// Module      : tage_top
// Description : Two-level TAGE direction predictor. It has a PC-indexed
//               bimodal base table (T0) and one tagged, history-indexed
//               table (T1), with a 32-bit global history register.
// Revision    : 1.0 - initial release
// ============================================================================
module tage_top #(
  parameter int T0_IDX_BITS = 8,
  parameter int T1_IDX_BITS = 6,
  parameter int T1_TAG_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] branch_pc,
  output logic [1:0]  branch_pred,
  input  logic        update_valid,
  input  logic [31:0] update_pc,
  input  logic        update_taken,
  input  logic [1:0]  update_pred,
  output logic [31:0] debug_ghr
);

  localparam int c_t0_entries = 1 << T0_IDX_BITS;
  localparam int c_t1_entries = 1 << T1_IDX_BITS;

  logic [1:0]             r_t0_ctr   [c_t0_entries];
  logic                   r_t1_valid [c_t1_entries];
  logic [T1_TAG_BITS-1:0] r_t1_tag   [c_t1_entries];
  logic [1:0]             r_t1_ctr   [c_t1_entries];
  logic [31:0]            r_ghr;

  logic [T0_IDX_BITS-1:0] w_p_t0i, w_u_t0i;
  logic [T1_IDX_BITS-1:0] w_p_t1i, w_u_t1i;
  logic [T1_TAG_BITS-1:0] w_p_t1t, w_u_t1t;
  logic                   w_p_hit, w_u_hit, w_mispredict;
  logic                   w_unused;

  function automatic logic [1:0] f_sat(input logic [1:0] ctr, input logic taken);
    if (taken) return (ctr == 2'b11) ? ctr : ctr + 2'd1;
    else       return (ctr == 2'b00) ? ctr : ctr - 2'd1;
  endfunction

  // Fetch and resolve lookups both hash against the registered (pre-shift) GHR
  assign w_p_t0i = branch_pc[T0_IDX_BITS+1:2];
  assign w_p_t1i = branch_pc[T1_IDX_BITS+1:2] ^ r_ghr[T1_IDX_BITS-1:0];
  assign w_p_t1t = branch_pc[T1_TAG_BITS+9:10] ^ r_ghr[T1_TAG_BITS-1:0];
  assign w_p_hit = r_t1_valid[w_p_t1i] && (r_t1_tag[w_p_t1i] == w_p_t1t);

  assign w_u_t0i = update_pc[T0_IDX_BITS+1:2];
  assign w_u_t1i = update_pc[T1_IDX_BITS+1:2] ^ r_ghr[T1_IDX_BITS-1:0];
  assign w_u_t1t = update_pc[T1_TAG_BITS+9:10] ^ r_ghr[T1_TAG_BITS-1:0];
  assign w_u_hit = r_t1_valid[w_u_t1i] && (r_t1_tag[w_u_t1i] == w_u_t1t);

  assign w_mispredict = update_pred[1] != update_taken;

  assign branch_pred = w_p_hit ? r_t1_ctr[w_p_t1i] : r_t0_ctr[w_p_t0i];
  assign debug_ghr   = r_ghr;
  assign w_unused    = ^{branch_pc, update_pc, update_pred[0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ghr <= '0;
      for (int i = 0; i < c_t0_entries; i++) r_t0_ctr[i] <= 2'b01;
      for (int j = 0; j < c_t1_entries; j++) begin
        r_t1_valid[j] <= 1'b0;
        r_t1_tag[j]   <= '0;
        r_t1_ctr[j]   <= 2'b01;
      end
    end else if (update_valid) begin
      if (w_u_hit) begin
        r_t1_ctr[w_u_t1i] <= f_sat(r_t1_ctr[w_u_t1i], update_taken);
      end else begin
        r_t0_ctr[w_u_t0i] <= f_sat(r_t0_ctr[w_u_t0i], update_taken);
        // Base table was the provider and got it wrong: claim a tagged entry
        if (w_mispredict) begin
          r_t1_valid[w_u_t1i] <= 1'b1;
          r_t1_tag[w_u_t1i]   <= w_u_t1t;
          r_t1_ctr[w_u_t1i]   <= update_taken ? 2'b10 : 2'b01;
        end
      end
      r_ghr <= {r_ghr[30:0], update_taken};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tage_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_tage_top
// Description : Self-checking bench for tage_top: directed vector table,
//               same-cycle read/write check and randomized model comparison.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tage_top;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] branch_pc = '0;
  logic [1:0]  branch_pred;
  logic        update_valid = 1'b0;
  logic [31:0] update_pc = '0;
  logic        update_taken = 1'b0;
  logic [1:0]  update_pred = '0;
  logic [31:0] debug_ghr;

  int tests = 0;
  int fails = 0;

  tage_top dut (
    .clk(clk), .rst(rst), .branch_pc(branch_pc), .branch_pred(branch_pred),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
    .update_pred(update_pred), .debug_ghr(debug_ghr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        uv;
    logic [31:0] upc;
    logic        tk;
    logic [1:0]  up;
    logic [31:0] bpc;
    logic        chk_pred;
    logic [1:0]  exp_pred;
    logic [31:0] exp_ghr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic uv, logic [31:0] upc, logic tk, logic [1:0] up,
                              logic [31:0] bpc, logic cp, logic [1:0] ep, logic [31:0] eg);
    vec_t v;
    v.rst = r; v.uv = uv; v.upc = upc; v.tk = tk; v.up = up;
    v.bpc = bpc; v.chk_pred = cp; v.exp_pred = ep; v.exp_ghr = eg;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: plain arrays and arithmetic on the documented hashes
  int          m_t0  [256];
  int          m_ctr [64];
  int          m_tag [64];
  bit          m_v   [64];
  logic [31:0] m_ghr;

  function automatic int f_t0i(logic [31:0] pc);
    return int'((pc >> 2) % 256);
  endfunction
  function automatic int f_t1i(logic [31:0] pc, logic [31:0] g);
    return int'(((pc >> 2) % 64) ^ (g % 64));
  endfunction
  function automatic int f_t1t(logic [31:0] pc, logic [31:0] g);
    return int'(((pc >> 10) % 256) ^ (g % 256));
  endfunction

  function automatic bit m_hit(logic [31:0] pc);
    int i = f_t1i(pc, m_ghr);
    return m_v[i] && (m_tag[i] == f_t1t(pc, m_ghr));
  endfunction

  function automatic logic [1:0] m_pred(logic [31:0] pc);
    if (m_hit(pc)) return 2'(m_ctr[f_t1i(pc, m_ghr)]);
    return 2'(m_t0[f_t0i(pc)]);
  endfunction

  function automatic int bump(int c, bit tk);
    if (tk) return (c >= 3) ? 3 : c + 1;
    return (c <= 0) ? 0 : c - 1;
  endfunction

  task automatic m_reset();
    m_ghr = '0;
    for (int i = 0; i < 256; i++) m_t0[i] = 1;
    for (int j = 0; j < 64; j++) begin m_v[j] = 0; m_tag[j] = 0; m_ctr[j] = 1; end
  endtask

  task automatic m_update(logic [31:0] pc, bit tk, logic [1:0] up);
    int i1 = f_t1i(pc, m_ghr);
    if (m_hit(pc)) begin
      m_ctr[i1] = bump(m_ctr[i1], tk);
    end else begin
      m_t0[f_t0i(pc)] = bump(m_t0[f_t0i(pc)], tk);
      if (up[1] != tk) begin
        m_v[i1] = 1; m_tag[i1] = f_t1t(pc, m_ghr); m_ctr[i1] = tk ? 2 : 1;
      end
    end
    m_ghr = {m_ghr[30:0], tk};
  endtask

  function automatic logic [31:0] rand_pc();
    return (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 15)) << 2)
         | (32'($urandom_range(0, 1)) << 20);
  endfunction

  initial begin
    // Reset, then GHR shift pattern 1,0,0,1,1 and one more taken
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,   1, 2'b01, 32'h0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h40,  1, 2'b01, 32'h0));
    vecs.push_back(mk(0, 1, 32'h100, 1, 2'b11, 0, 0, 0, 32'b1));
    vecs.push_back(mk(0, 1, 32'h100, 0, 2'b00, 0, 0, 0, 32'b10));
    vecs.push_back(mk(0, 1, 32'h100, 0, 2'b00, 0, 0, 0, 32'b100));
    vecs.push_back(mk(0, 1, 32'h100, 1, 2'b11, 0, 0, 0, 32'b1001));
    vecs.push_back(mk(0, 1, 32'h100, 1, 2'b11, 0, 0, 0, 32'b10011));
    vecs.push_back(mk(0, 1, 32'h100, 1, 2'b11, 0, 0, 0, 32'b100111));
    // T0 training on 0x40 with saturation
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h40, 1, 2'b01, 32'h0));
    vecs.push_back(mk(0, 1, 32'h40, 1, 2'b11, 32'h40, 1, 2'b10, 32'b1));
    vecs.push_back(mk(0, 1, 32'h40, 1, 2'b11, 32'h40, 1, 2'b11, 32'b11));
    vecs.push_back(mk(0, 1, 32'h40, 1, 2'b11, 32'h40, 1, 2'b11, 32'b111));
    // T1 allocation on mispredict, then T1 provider update and saturation
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h40, 1, 2'b01, 32'h0));
    vecs.push_back(mk(0, 1, 32'h40, 0, 2'b10, 32'h40, 1, 2'b01, 32'h0));
    vecs.push_back(mk(0, 1, 32'h40, 0, 2'b01, 32'h40, 1, 2'b00, 32'h0));
    vecs.push_back(mk(0, 1, 32'h40, 0, 2'b00, 32'h40, 1, 2'b00, 32'h0));
    // Hold with junk update inputs, then reset wins over an update
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0, 0, $urandom, 1'($urandom), 2'($urandom), 32'h40, 1, 2'b00, 32'h0));
    vecs.push_back(mk(1, 1, 32'h40, 1, 2'b11, 32'h40, 1, 2'b01, 32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst = vecs[i].rst; update_valid = vecs[i].uv; update_pc = vecs[i].upc;
      update_taken = vecs[i].tk; update_pred = vecs[i].up; branch_pc = vecs[i].bpc;
      @(posedge clk); #1;
      check($sformatf("vec%0d_ghr", i), debug_ghr, vecs[i].exp_ghr);
      if (vecs[i].chk_pred)
        check($sformatf("vec%0d_pred", i), 32'(branch_pred), 32'(vecs[i].exp_pred));
    end

    // Same-cycle read of an entry being written shows the old value
    @(negedge clk);
    rst = 0; update_valid = 1; update_pc = 32'h40; update_taken = 1; update_pred = 2'b01;
    branch_pc = 32'h40;
    #1 check("same_cycle_pred", 32'(branch_pred), 32'h1);
    @(posedge clk); #1;
    check("after_write_pred", 32'(branch_pred), 32'h2);
    check("after_write_ghr", debug_ghr, 32'h1);

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      logic        r, uv, tk;
      logic [31:0] upc, bpc;
      logic [1:0]  up;
      @(negedge clk);
      r   = (c == 0) || ($urandom_range(0, 59) == 0);
      uv  = $urandom_range(0, 3) != 0;
      upc = rand_pc();
      tk  = $urandom_range(0, 2) != 0;
      bpc = rand_pc();
      up  = (c > 0 && $urandom_range(0, 3) != 0) ? m_pred(upc) : 2'($urandom);
      rst = r; update_valid = uv; update_pc = upc; update_taken = tk;
      update_pred = up; branch_pc = bpc;
      #1;
      if (c > 0) check("rand_pred_pre", 32'(branch_pred), 32'(m_pred(bpc)));
      @(posedge clk);
      if (r) m_reset();
      else if (uv) m_update(upc, tk, up);
      #1;
      check("rand_ghr", debug_ghr, m_ghr);
      check("rand_pred_post", 32'(branch_pred), 32'(m_pred(bpc)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tage_top.md
# tage_top

Branch direction predictor for the front end. It is a two-level TAGE: a PC-indexed bimodal base table (T0) and one tagged, history-indexed table (T1), with a 32-bit global history register (GHR). Fetch gets a combinational 2-bit prediction for `branch_pc`. The resolve stage trains the tables and shifts the GHR through the update port.

## Interface
Parameters:
- `T0_IDX_BITS`, default 8: T0 has 2^8 entries, indexed by pc[9:2].
- `T1_IDX_BITS`, default 6: T1 has 2^6 entries.
- `T1_TAG_BITS`, default 8: T1 tag width.

Ports:
- `clk`, in, 1: single clock, all state updates on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `branch_pc`, in, 32: fetch PC to predict.
- `branch_pred`, out, 2: predicted counter; bit 1 = taken.
- `update_valid`, in, 1: resolved branch this cycle.
- `update_pc`, in, 32: PC of the resolved branch.
- `update_taken`, in, 1: actual outcome.
- `update_pred`, in, 2: `branch_pred` value that fetch used for this branch.
- `debug_ghr`, out, 32: current GHR register.

## Operation
- T0 entry: 2-bit saturating counter. T0 index t0i = pc[9:2].
- T1 entry fields:
  - valid bit
  - 8-bit tag
  - 2-bit counter
- T1 lookup:
  - index t1i = pc[7:2] XOR ghr[5:0]
  - tag t1t = pc[17:10] XOR ghr[7:0]
  - hit when valid and stored tag == t1t
- Prediction (combinational, from `branch_pc` and the current registered GHR):
  - T1 hit: `branch_pred` = T1 counter.
  - Otherwise: `branch_pred` = T0[t0i] counter.
- Update, when `update_valid`=1:
  - Recompute t0i, t1i, t1t from `update_pc` and the GHR value before this edge's shift.
  - mispredict = (update_pred[1] != update_taken).
  - T1 hit: T1 counter increments (taken) or decrements (not taken), saturating at 3/0. T0 is unchanged.
  - T1 miss: T0 counter increments or decrements, saturating at 3/0.
  - T1 miss and mispredict: allocate T1[t1i] with valid=1, tag=t1t, counter = 2'b10 if taken, else 2'b01. This overwrites unconditionally.
  - GHR <= {GHR[30:0], update_taken}. The newest outcome goes into bit 0.
- `update_valid`=0: no state changes. `update_pc`, `update_taken` and `update_pred` are ignored.
- `debug_ghr` is the GHR register driven directly.

## Timing
- Reset (synchronous, `rst`=1 at a rising edge), values the next cycle:
  - GHR = 0
  - every T0 counter = 2'b01
  - every T1 entry has valid=0, tag=0, counter=2'b01
  - `branch_pred` therefore = 2'b01 for any PC; `debug_ghr` = 0
- `rst` has priority over `update_valid` in the same cycle.
- Prediction has zero latency: it is combinational from registered state.
- Update latency is one cycle: state written at edge N is visible on `branch_pred` and `debug_ghr` after edge N.
- Prediction and update to the same entry in one cycle: `branch_pred` shows the pre-update value.
- Counter saturation:
  - 3 plus taken stays 3.
  - 0 plus not-taken stays 0.
- GHR has no wrap logic; bit 31 is discarded on each shift.
- One update per cycle at most. Back-to-back updates every cycle are supported.

## Test plan
- Reset: assert `rst` for one edge -> `debug_ghr`=0, `branch_pred`=2'b01 for `branch_pc` 0x0 and 0x40.
- GHR shift:
  - Stimulus: after reset, `update_valid`=1 for five consecutive edges with `update_taken` = 1,0,0,1,1.
  - Response: `debug_ghr`=32'b10011. One more taken update -> 32'b100111.
- T0 training:
  - Stimulus: after reset, two updates on `update_pc`=0x40, taken, `update_pred`=2'b11.
  - Response: T0[16] goes 01->10->11; GHR=0b11; `branch_pc`=0x40 -> `branch_pred`=2'b11 (T1 miss). A third taken update keeps 2'b11.
- T1 allocation and hit:
  - Stimulus: after reset, one update on `update_pc`=0x40, not taken, `update_pred`=2'b10 (mispredict).
  - Response: T0[16]=00; T1[0x10] is allocated with tag 0 and counter 01; GHR stays 0. `branch_pc`=0x40 -> `branch_pred`=2'b01, sourced from T1, not from T0's 00.
- T1 provider update:
  - Stimulus: continuing the previous case, update 0x40, not taken, `update_pred`=2'b01.
  - Response: T1 counter goes to 00, T0 stays 00, GHR=0. `branch_pred` for 0x40 = 2'b00.
- Hold and reset priority:
  - `update_valid`=0 with random update inputs for 5 cycles -> GHR and predictions unchanged.
  - `rst`=1 with `update_valid`=1 -> all state back to reset values.
